// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache fill controller:
//   - fill FSM state encoding
//   - NOP instruction returned whenever no valid word is delivered
//   - line geometry (words per line, byte-offset width)
//   - helpers that slice a byte address into line index and tag
// ---------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int          WORDS     = 4;
    // byte-in-word (1 bit) plus word-in-line (2 bits)
    localparam int          OFFSET_W  = 3;

    // Line index of a byte address, right-justified in 16 bits.
    function automatic logic [15:0] line_index(input logic [15:0] addr, input int idx_w);
        return (addr >> OFFSET_W) & ((16'd1 << idx_w) - 16'd1);
    endfunction

    // Tag of a byte address, right-justified in 16 bits.
    function automatic logic [15:0] line_tag(input logic [15:0] addr, input int idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
// Flop-based storage for a direct-mapped cache: per-line valid bit, tag and
// WORDS x 16-bit data words. One combinational read port, one write port.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rd_idx/rd_word read line index / word within line
//   rd_valid       valid bit of the addressed line
//   rd_tag         stored tag of the addressed line
//   rd_data        addressed data word
//   wr_en          write wr_data into word wr_word of line wr_idx
//   valid_clr      clear valid of line wr_idx (start of a refill)
//   valid_set      set valid and write wr_tag for line wr_idx (refill done)
// ---------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDXW  = 4,
    parameter int TAGW  = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [1:0]      rd_word,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [15:0]     rd_data,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [1:0]      wr_word,
    input  logic [15:0]     wr_data,
    input  logic            valid_clr,
    input  logic            valid_set,
    input  logic [TAGW-1:0] wr_tag
);

    logic [LINES-1:0] valid_r;
    logic [TAGW-1:0]  tag_r  [LINES];
    logic [15:0]      data_r [LINES*WORDS];

    // Valid bits and tags: cleared on reset, updated by the refill sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (valid_set) begin
                valid_r[wr_idx] <= 1'b1;
                tag_r[wr_idx]   <= wr_tag;
            end else if (valid_clr) begin
                valid_r[wr_idx] <= 1'b0;
            end
        end
    end

    // Data words: one word written per returned memory beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINES*WORDS; i++) begin
                data_r[i] <= 16'h0000;
            end
        end else begin
            if (wr_en) begin
                data_r[{wr_idx, wr_word}] <= wr_data;
            end
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
// Direct-mapped instruction cache between fetch and backing memory. Hits
// return the 16-bit word in the same cycle; misses stall fetch while the
// 4-word line is filled one single-beat read at a time.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   fetch_req/fetch_addr  fetch request and byte address (PC)
//   flush                 redirect; drops delivery of a pending miss
//   fetch_instr           instruction word, NOP when fetch_valid=0
//   fetch_valid           fetch_instr valid for fetch_addr (IDLE hit only)
//   stall                 fetch must hold its PC
//   err                   misaligned fetch (fetch_addr[0]=1)
//   mem_rd/mem_addr       one-cycle read strobe and word-aligned address
//   mem_rvalid/mem_rdata  read data return (latency >= 1)
//   hit_cnt/miss_cnt      saturating statistics, only with ICACHE_STATS_EN
//
// Optional feature macro: ICACHE_STATS_EN
// ---------------------------------------------------------------------------
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        flush,
    output logic [15:0] fetch_instr,
    output logic        fetch_valid,
    output logic        stall,
    output logic        err,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 16 - OFFSET_W - IDXW;

    fill_state_t     state_r;
    fill_state_t     state_nxt_s;
    logic [1:0]      beat_r;
    logic [1:0]      beat_nxt_s;
    logic [15:0]     base_r;
    logic [15:0]     base_nxt_s;

    logic            req_s;
    logic            lookup_s;
    logic            hit_s;
    logic            miss_s;
    logic            wr_en_s;
    logic            valid_clr_s;
    logic            valid_set_s;

    logic [IDXW-1:0] fetch_idx_s;
    logic [TAGW-1:0] fetch_tag_s;
    logic [IDXW-1:0] fill_idx_s;
    logic [TAGW-1:0] fill_tag_s;
    logic            rd_valid_s;
    logic [TAGW-1:0] rd_tag_s;
    logic [15:0]     rd_data_s;

    assign fetch_idx_s = IDXW'(line_index(fetch_addr, IDXW));
    assign fetch_tag_s = TAGW'(line_tag(fetch_addr, IDXW));
    assign fill_idx_s  = IDXW'(line_index(base_r, IDXW));
    assign fill_tag_s  = TAGW'(line_tag(base_r, IDXW));

    icache_array #(
        .LINES (LINES),
        .IDXW  (IDXW),
        .TAGW  (TAGW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (fetch_idx_s),
        .rd_word   (fetch_addr[2:1]),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (wr_en_s),
        .wr_idx    (fill_idx_s),
        .wr_word   (beat_r),
        .wr_data   (mem_rdata),
        .valid_clr (valid_clr_s),
        .valid_set (valid_set_s),
        .wr_tag    (fill_tag_s)
    );

    // Lookup, fetch-side outputs, memory strobe and fill next-state.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        base_nxt_s  = base_r;
        wr_en_s     = 1'b0;
        valid_clr_s = 1'b0;
        valid_set_s = 1'b0;
        mem_addr    = 16'h0000;

        // Requests are ignored while reset is held so every output sits at
        // its reset value regardless of what fetch is driving.
        req_s    = fetch_req & rst;
        // Flush wins over a lookup: no delivery and no fill start.
        lookup_s = (state_r == IDLE) & req_s & ~fetch_addr[0] & ~flush;
        hit_s    = lookup_s & rd_valid_s & (rd_tag_s == fetch_tag_s);
        miss_s   = lookup_s & ~hit_s;

        fetch_valid = hit_s;
        if (hit_s) begin
            fetch_instr = rd_data_s;
        end else begin
            fetch_instr = NOP_INSTR;
        end
        err    = req_s & fetch_addr[0];
        stall  = miss_s | (state_r != IDLE);
        mem_rd = (state_r == REQ);

        // A flush arriving mid-fill needs no state of its own: delivery only
        // ever happens through a fresh IDLE lookup of whatever PC fetch
        // presents after DONE, so the cancelled request is simply never seen.
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    base_nxt_s  = fetch_addr & ~16'h0007;
                    beat_nxt_s  = 2'd0;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                mem_addr    = base_r + {13'd0, beat_r, 1'b0};
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wr_en_s     = 1'b1;
                    // Invalidate on the first beat so a half-written line
                    // can never produce a hit.
                    valid_clr_s = (beat_r == 2'd0);
                    if (beat_r == 2'd3) begin
                        valid_set_s = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        beat_nxt_s  = beat_r + 2'd1;
                        state_nxt_s = REQ;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Fill FSM state, beat counter and latched line base address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            beat_r  <= 2'd0;
            base_r  <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            base_r  <= base_nxt_s;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit / fill-start counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (hit_s && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (miss_s && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
